// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer datapath: opcode indices,
// register-reference bit positions and the sequence-counter steps that execute them.
package mano_pkg;

  localparam int unsigned OP_AND = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_LDA = 2;
  localparam int unsigned OP_STA = 3;
  localparam int unsigned OP_BUN = 4;
  localparam int unsigned OP_BSA = 5;
  localparam int unsigned OP_ISZ = 6;
  localparam int unsigned OP_REG = 7;

  localparam int unsigned RR_CLA = 11;
  localparam int unsigned RR_CLE = 10;
  localparam int unsigned RR_CMA = 9;
  localparam int unsigned RR_CME = 8;
  localparam int unsigned RR_CIR = 7;
  localparam int unsigned RR_CIL = 6;
  localparam int unsigned RR_INC = 5;
  localparam int unsigned RR_SPA = 4;
  localparam int unsigned RR_SNA = 3;
  localparam int unsigned RR_SZA = 2;
  localparam int unsigned RR_SZE = 1;
  localparam int unsigned RR_HLT = 0;

  localparam logic [2:0] T_EXEC_REG = 3'd3;
  localparam logic [2:0] T_EXEC_MEM = 3'd5;

endpackage

// File: rtl/mano_decode.sv
// 3-to-8 one-hot decoder, shared by the register blocks for opcode (D) and
// sequence-counter (T) decoding.
module mano_decode (
  input  logic [2:0] i_sel,
  output logic [7:0] o_onehot
);

  always_comb begin
    o_onehot = 8'b0000_0001 << i_sel;
  end

endmodule

// File: rtl/reg_ac_alu.sv
// Accumulator, E flip-flop and ALU of the Mano basic computer. Executes
// AND/ADD/LDA at T5 and register-reference instructions at T3; drives SKIP and HALT.
module reg_ac_alu
  import mano_pkg::*;
#(
  parameter logic [15:0] AC_INIT = 16'h0000,
  parameter logic        E_INIT  = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] IN_IR,
  input  logic [15:0] IN_DR,
  input  logic [2:0]  t,
  output logic [15:0] Q_AC,
  output logic        Q_E,
  output logic        SKIP,
  output logic        HALT
);

  logic [15:0] r_ac;
  logic        r_e;
  logic        r_halt;

  logic [7:0]  w_d;
  logic [7:0]  w_t;
  logic [11:0] w_b;
  logic        w_r;
  logic        w_rr_legal;
  logic        w_exec_rr;
  logic        w_exec_mem;
  logic        w_skip_cond;
  logic [15:0] w_ac_nxt;
  logic        w_e_nxt;
  logic        w_halt_nxt;
  logic        w_unused;

  mano_decode u_dec_op (
    .i_sel    (IN_IR[14:12]),
    .o_onehot (w_d)
  );

  mano_decode u_dec_t (
    .i_sel    (t),
    .o_onehot (w_t)
  );

  // Opcodes and T steps owned by other register blocks are intentionally ignored here.
  assign w_unused = &{1'b0, w_d[6:3], w_t[7:6], w_t[4], w_t[2:0]};

  assign w_b        = IN_IR[11:0];
  assign w_r        = w_d[OP_REG] & ~IN_IR[15] & w_t[T_EXEC_REG];
  assign w_rr_legal = (w_b != 12'd0) && ((w_b & (w_b - 12'd1)) == 12'd0);
  assign w_exec_rr  = w_r & w_rr_legal & ~r_halt;
  assign w_exec_mem = w_t[T_EXEC_MEM] & ~r_halt;

  assign w_skip_cond = (w_b[RR_SPA] & ~r_ac[15])
                     | (w_b[RR_SNA] &  r_ac[15])
                     | (w_b[RR_SZA] & (r_ac == 16'd0))
                     | (w_b[RR_SZE] & ~r_e);

  assign SKIP = ~RST & w_exec_rr & w_skip_cond;

  // NOTE: every output of this block gets its hold value first, so a path that
  // assigns nothing keeps the register value instead of inferring a latch.
  always_comb begin
    w_ac_nxt   = r_ac;
    w_e_nxt    = r_e;
    w_halt_nxt = r_halt;
    if (w_exec_mem) begin
      if (w_d[OP_AND])      w_ac_nxt = r_ac & IN_DR;
      else if (w_d[OP_ADD]) {w_e_nxt, w_ac_nxt} = {1'b0, r_ac} + {1'b0, IN_DR};
      else if (w_d[OP_LDA]) w_ac_nxt = IN_DR;
    end else if (w_exec_rr) begin
      // Legality guarantees exactly one bit of w_b is set here.
      case (1'b1)
        w_b[RR_CLA]: w_ac_nxt = 16'd0;
        w_b[RR_CLE]: w_e_nxt  = 1'b0;
        w_b[RR_CMA]: w_ac_nxt = ~r_ac;
        w_b[RR_CME]: w_e_nxt  = ~r_e;
        w_b[RR_CIR]: begin
          w_ac_nxt = {r_e, r_ac[15:1]};
          w_e_nxt  = r_ac[0];
        end
        w_b[RR_CIL]: begin
          w_ac_nxt = {r_ac[14:0], r_e};
          w_e_nxt  = r_ac[15];
        end
        w_b[RR_INC]: w_ac_nxt = r_ac + 16'd1;
        w_b[RR_HLT]: w_halt_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ac   <= AC_INIT;
      r_e    <= E_INIT;
      r_halt <= 1'b0;
    end else begin
      r_ac   <= w_ac_nxt;
      r_e    <= w_e_nxt;
      r_halt <= w_halt_nxt;
    end
  end

  assign Q_AC = r_ac;
  assign Q_E  = r_e;
  assign HALT = r_halt;

endmodule
